// File: rtl/pdp8_pkg.sv
// pdp8_pkg: shared PDP-8 word widths and memory arbiter types
package pdp8_pkg;
  localparam int PDP8_ADDR_WIDTH = 12;
  localparam int PDP8_DATA_WIDTH = 12;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_e;
  typedef enum logic {OWN_IFD, OWN_EXEC} mem_owner_e;
endpackage

// File: rtl/pdp8_mem_arb_sel.sv
// pdp8_mem_arb_sel: EXEC-priority pick with a streak counter bounding IFD starvation
module pdp8_mem_arb_sel
  import pdp8_pkg::*;
#(
  parameter int MAX_EXEC_BURST = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ifd_req,
  input  logic       exec_req,
  input  logic       arb_en,
  output logic       pick_valid,
  output mem_owner_e pick_owner
);
  logic [3:0] streak;
  // EXEC wins ties until it has won MAX_EXEC_BURST times in a row over a waiting IFD
  always_comb begin
    pick_valid = ifd_req | exec_req;
    pick_owner = (exec_req && !(ifd_req && streak == 4'(MAX_EXEC_BURST))) ? OWN_EXEC : OWN_IFD;
  end
  // count EXEC wins taken while IFD waited; any other arbitration restarts the count
  always_ff @(posedge clk) begin
    if (!reset_n) streak <= '0;
    else if (arb_en && pick_valid) streak <= (pick_owner == OWN_EXEC && ifd_req) ? streak + 4'd1 : '0;
  end
endmodule

// File: rtl/pdp8_mem_arbiter.sv
// pdp8_mem_arbiter: shares single-port main memory between IFD fetches and EXEC accesses
module pdp8_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int ADDR_WIDTH     = PDP8_ADDR_WIDTH,
  parameter int DATA_WIDTH     = PDP8_DATA_WIDTH,
  parameter int MEM_LATENCY    = 2,
  parameter int MAX_EXEC_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifd_req,
  input  logic [ADDR_WIDTH-1:0] ifd_addr,
  output logic                  ifd_gnt,
  output logic [DATA_WIDTH-1:0] ifd_rdata,
  output logic                  ifd_rvalid,
  input  logic                  exec_req,
  input  logic                  exec_we,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [DATA_WIDTH-1:0] exec_wdata,
  output logic                  exec_gnt,
  output logic [DATA_WIDTH-1:0] exec_rdata,
  output logic                  exec_rvalid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  arb_state_e state;
  mem_owner_e owner, pick_owner;
  logic       pick_valid, exec_pick;
  logic [2:0] lat_cnt;
  assign exec_pick = pick_owner == OWN_EXEC;
  assign busy = state != ARB_IDLE;
  pdp8_mem_arb_sel #(.MAX_EXEC_BURST(MAX_EXEC_BURST)) u_sel (
    .clk        (clk),
    .reset_n    (reset_n),
    .ifd_req    (ifd_req),
    .exec_req   (exec_req),
    .arb_en     (state == ARB_IDLE),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );
  // transaction FSM; the mem_* registers double as the request latch during ISSUE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ARB_IDLE;
      owner       <= OWN_IFD;
      lat_cnt     <= '0;
      ifd_gnt     <= 1'b0;
      exec_gnt    <= 1'b0;
      ifd_rvalid  <= 1'b0;
      exec_rvalid <= 1'b0;
      ifd_rdata   <= '0;
      exec_rdata  <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      ifd_gnt     <= 1'b0;
      exec_gnt    <= 1'b0;
      ifd_rvalid  <= 1'b0;
      exec_rvalid <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      case (state)
        ARB_IDLE: if (pick_valid) begin
          state     <= ARB_ISSUE;
          owner     <= pick_owner;
          ifd_gnt   <= !exec_pick;
          exec_gnt  <= exec_pick;
          mem_req   <= 1'b1;
          mem_we    <= exec_pick && exec_we;
          mem_addr  <= exec_pick ? exec_addr : ifd_addr;
          mem_wdata <= exec_pick ? exec_wdata : '0;
        end
        ARB_ISSUE: begin
          state   <= mem_we ? ARB_IDLE : ARB_WAIT;
          lat_cnt <= 3'(MEM_LATENCY - 1);
        end
        ARB_WAIT: if (lat_cnt == 3'd0) begin
          state       <= ARB_RESP;
          ifd_rvalid  <= owner == OWN_IFD;
          exec_rvalid <= owner == OWN_EXEC;
          ifd_rdata   <= owner == OWN_IFD ? mem_rdata : ifd_rdata;
          exec_rdata  <= owner == OWN_EXEC ? mem_rdata : exec_rdata;
        end else lat_cnt <= lat_cnt - 3'd1;
        ARB_RESP: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// tb_pdp8_mem_arbiter: randomized and directed checks of the memory arbiter against a transaction-level model
module tb_pdp8_mem_arbiter;
  localparam int L = 2;
  localparam int MAXB = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic ifd_req = 0, exec_req = 0, exec_we = 0;
  logic [11:0] ifd_addr = 0, exec_addr = 0, exec_wdata = 0;
  logic ifd_gnt, ifd_rvalid, exec_gnt, exec_rvalid, mem_req, mem_we, busy;
  logic [11:0] ifd_rdata, exec_rdata, mem_addr, mem_wdata, mem_rdata;
  logic ifd_req1 = 0, exec_req1 = 0, exec_we1 = 0;
  logic [11:0] ifd_addr1 = 0, exec_addr1 = 0, exec_wdata1 = 0;
  logic ifd_gnt1, ifd_rvalid1, exec_gnt1, exec_rvalid1, mem_req1, mem_we1, busy1;
  logic [11:0] ifd_rdata1, exec_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [11:0] mem_arr [4096];
  logic [11:0] pipe [L];
  logic [11:0] pipe1;
  logic pl_en = 0;
  logic [11:0] pl_addr = 0, pl_data = 0;
  logic [11:0] ref_mem [4096];
  int pass_cnt = 0, total = 0;
  bit t_ig[128], t_eg[128], t_ir[128], t_er[128], t_mr[128], t_mw[128], t_busy[128];
  logic [11:0] t_maddr[128], t_mwdata[128], t_ird[128], t_erd[128];

  always #5 clk = ~clk;

  pdp8_mem_arbiter #(.MEM_LATENCY(L), .MAX_EXEC_BURST(MAXB)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifd_req(ifd_req), .ifd_addr(ifd_addr), .ifd_gnt(ifd_gnt), .ifd_rdata(ifd_rdata), .ifd_rvalid(ifd_rvalid),
    .exec_req(exec_req), .exec_we(exec_we), .exec_addr(exec_addr), .exec_wdata(exec_wdata),
    .exec_gnt(exec_gnt), .exec_rdata(exec_rdata), .exec_rvalid(exec_rvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy));

  pdp8_mem_arbiter #(.MEM_LATENCY(1), .MAX_EXEC_BURST(MAXB)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .ifd_req(ifd_req1), .ifd_addr(ifd_addr1), .ifd_gnt(ifd_gnt1), .ifd_rdata(ifd_rdata1), .ifd_rvalid(ifd_rvalid1),
    .exec_req(exec_req1), .exec_we(exec_we1), .exec_addr(exec_addr1), .exec_wdata(exec_wdata1),
    .exec_gnt(exec_gnt1), .exec_rdata(exec_rdata1), .exec_rvalid(exec_rvalid1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .busy(busy1));

  // memory model: data valid exactly MEM_LATENCY cycles after the request cycle, junk otherwise
  always @(posedge clk) begin
    if (pl_en) mem_arr[pl_addr] <= pl_data;
    if (mem_req && mem_we) mem_arr[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_req && !mem_we) ? mem_arr[mem_addr] : 12'($urandom);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    pipe1 <= mem_req1 ? mem_arr[mem_addr1] : 12'($urandom);
  end
  assign mem_rdata = pipe[L-1];
  assign mem_rdata1 = pipe1;

  task automatic preload(input logic [11:0] a, input logic [11:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 0;
    ref_mem[a] = d;
  endtask

  task automatic capture(input int n, input bit auto_drop, input int inj);
    for (int i = 0; i < 128; i++) begin
      t_ig[i] = 0; t_eg[i] = 0; t_ir[i] = 0; t_er[i] = 0; t_mr[i] = 0; t_mw[i] = 0; t_busy[i] = 0;
      t_maddr[i] = 0; t_mwdata[i] = 0; t_ird[i] = 0; t_erd[i] = 0;
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      t_ig[i] = ifd_gnt; t_eg[i] = exec_gnt; t_ir[i] = ifd_rvalid; t_er[i] = exec_rvalid;
      t_mr[i] = mem_req; t_mw[i] = mem_we; t_busy[i] = busy;
      t_maddr[i] = mem_addr; t_mwdata[i] = mem_wdata; t_ird[i] = ifd_rdata; t_erd[i] = exec_rdata;
      if (inj == i) ifd_req = 1;
      if (auto_drop && ifd_gnt) begin ifd_req = 0; ifd_addr = 12'($urandom); end
      if (auto_drop && exec_gnt) begin
        exec_req = 0; exec_addr = 12'($urandom); exec_wdata = 12'($urandom); exec_we = 1'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    exec_req = 1; ifd_req = 1; reset_n = 0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 0) $display("FAIL reset_busy got %0b exp 0", busy); else pass_cnt++;
    total++; if ({ifd_gnt, exec_gnt, ifd_rvalid, exec_rvalid} !== 4'b0) $display("FAIL reset_pulses got %b exp 0000", {ifd_gnt, exec_gnt, ifd_rvalid, exec_rvalid}); else pass_cnt++;
    total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== 26'b0) $display("FAIL reset_mem got %0b/%0b/%o/%o exp 0", mem_req, mem_we, mem_addr, mem_wdata); else pass_cnt++;
    total++; if ({ifd_rdata, exec_rdata} !== 24'b0) $display("FAIL reset_rdata got %o/%o exp 0", ifd_rdata, exec_rdata); else pass_cnt++;
    exec_req = 0; ifd_req = 0; reset_n = 1;
    @(negedge clk);
    total++; if (busy !== 0 || busy1 !== 0) $display("FAIL reset_idle got %0b/%0b exp 0", busy, busy1); else pass_cnt++;
  endtask

  task automatic test_ifd_read();
    preload(12'o0200, 12'o7402);
    ifd_addr = 12'o0200; ifd_req = 1;
    capture(8, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      total++; if (t_ig[i] !== (i == 1) || t_mr[i] !== (i == 1)) $display("FAIL ifd_read_gnt c%0d got %0b/%0b exp %0b", i, t_ig[i], t_mr[i], i == 1); else pass_cnt++;
      total++; if (t_ir[i] !== (i == 2 + L) || t_eg[i] || t_er[i]) $display("FAIL ifd_read_rvalid c%0d got %0b exp %0b", i, t_ir[i], i == 2 + L); else pass_cnt++;
      total++; if (t_busy[i] !== (i <= 2 + L)) $display("FAIL ifd_read_busy c%0d got %0b exp %0b", i, t_busy[i], i <= 2 + L); else pass_cnt++;
    end
    total++; if (t_maddr[1] !== 12'o0200 || t_mw[1] !== 0) $display("FAIL ifd_read_addr got %o we %0b exp 0200 we 0", t_maddr[1], t_mw[1]); else pass_cnt++;
    total++; if (t_ird[2+L] !== 12'o7402) $display("FAIL ifd_read_data got %o exp 7402", t_ird[2+L]); else pass_cnt++;
    total++; if (t_maddr[2] !== 0) $display("FAIL ifd_read_addr_idle got %o exp 0", t_maddr[2]); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic [11:0] de, di;
    de = 12'($urandom); di = 12'($urandom);
    preload(12'o0300, de); preload(12'o0201, di);
    exec_we = 0; exec_addr = 12'o0300; ifd_addr = 12'o0201; exec_req = 1; ifd_req = 1;
    capture(12, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      total++; if (t_eg[i] !== (i == 1) || t_ig[i] !== (i == 4 + L)) $display("FAIL simul_gnt c%0d got e%0b i%0b", i, t_eg[i], t_ig[i]); else pass_cnt++;
      total++; if (t_er[i] !== (i == 2 + L) || t_ir[i] !== (i == 5 + 2 * L)) $display("FAIL simul_rvalid c%0d got e%0b i%0b", i, t_er[i], t_ir[i]); else pass_cnt++;
    end
    total++; if (t_maddr[1] !== 12'o0300 || t_maddr[4+L] !== 12'o0201) $display("FAIL simul_addr got %o/%o exp 0300/0201", t_maddr[1], t_maddr[4+L]); else pass_cnt++;
    total++; if (t_erd[2+L] !== de || t_ird[5+2*L] !== di) $display("FAIL simul_data got %o/%o exp %o/%o", t_erd[2+L], t_ird[5+2*L], de, di); else pass_cnt++;
  endtask

  task automatic test_exec_write();
    preload(12'o0204, 12'o4321);
    exec_we = 1; exec_addr = 12'o0310; exec_wdata = 12'o1234; exec_req = 1;
    ifd_addr = 12'o0204; ifd_req = 0;
    capture(8, 1, 2);
    for (int i = 1; i <= 8; i++) begin
      total++; if (t_eg[i] !== (i == 1) || t_er[i]) $display("FAIL write_gnt c%0d got g%0b rv%0b", i, t_eg[i], t_er[i]); else pass_cnt++;
      total++; if (t_mr[i] !== (i == 1 || i == 3) || t_mw[i] !== (i == 1)) $display("FAIL write_mem c%0d got req%0b we%0b", i, t_mr[i], t_mw[i]); else pass_cnt++;
    end
    total++; if (t_maddr[1] !== 12'o0310 || t_mwdata[1] !== 12'o1234) $display("FAIL write_bus got %o/%o exp 0310/1234", t_maddr[1], t_mwdata[1]); else pass_cnt++;
    total++; if (t_busy[2] !== 0 || t_maddr[2] !== 0 || t_mwdata[2] !== 0) $display("FAIL write_idle got busy%0b %o/%o", t_busy[2], t_maddr[2], t_mwdata[2]); else pass_cnt++;
    total++; if (t_ig[3] !== 1 || t_maddr[3] !== 12'o0204) $display("FAIL write_then_ifd got gnt%0b addr %o exp 1/0204", t_ig[3], t_maddr[3]); else pass_cnt++;
    total++; if (t_ir[3+L+1] !== 1 || t_ird[3+L+1] !== 12'o4321) $display("FAIL write_then_ifd_data got %0b/%o exp 1/4321", t_ir[3+L+1], t_ird[3+L+1]); else pass_cnt++;
    total++; if (mem_arr[12'o0310] !== 12'o1234) $display("FAIL write_stored got %o exp 1234", mem_arr[12'o0310]); else pass_cnt++;
    ref_mem[12'o0310] = 12'o1234;
  endtask

  task automatic test_fairness();
    byte seq[$];
    byte exp;
    int dbl, run, max_run;
    exec_we = 0; exec_addr = 12'($urandom); ifd_addr = 12'($urandom); exec_req = 1; ifd_req = 1;
    capture(60, 0, 0);
    exec_req = 0; ifd_req = 0;
    dbl = 0;
    for (int i = 1; i <= 60; i++) begin
      if (t_ig[i] && t_eg[i]) dbl++;
      if (t_eg[i]) seq.push_back("E");
      if (t_ig[i]) seq.push_back("I");
    end
    total++; if (dbl != 0) $display("FAIL fair_double_gnt got %0d cycles exp 0", dbl); else pass_cnt++;
    for (int k = 0; k < 10; k++) begin
      exp = (k % (MAXB + 1) == MAXB) ? "I" : "E";
      total++;
      if (seq.size() <= k) $display("FAIL fair_seq[%0d] got none exp %c", k, exp);
      else if (seq[k] != exp) $display("FAIL fair_seq[%0d] got %c exp %c", k, seq[k], exp);
      else pass_cnt++;
    end
    run = 0; max_run = 0;
    foreach (seq[k]) begin
      run = (seq[k] == "E") ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    total++; if (max_run > MAXB) $display("FAIL fair_starve got %0d exp <=%0d", max_run, MAXB); else pass_cnt++;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    total++; if (busy !== 0) $display("FAIL fair_drain got busy %0b exp 0", busy); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit use_exec, we;
    logic [11:0] a, d;
    for (int k = 0; k < 8; k++) preload(12'o0400 + 12'(k), 12'($urandom));
    for (int k = 0; k < 24; k++) begin
      use_exec = 1'($urandom_range(0, 1));
      we = use_exec && 1'($urandom_range(0, 1));
      a = 12'o0400 + 12'($urandom_range(0, 7));
      d = 12'($urandom);
      if (use_exec) begin exec_req = 1; exec_we = we; exec_addr = a; exec_wdata = d; end
      else begin ifd_req = 1; ifd_addr = a; end
      capture(6, 1, 0);
      total++; if (t_eg[1] !== use_exec || t_ig[1] !== !use_exec) $display("FAIL rand%0d_gnt got e%0b i%0b exp e%0b", k, t_eg[1], t_ig[1], use_exec); else pass_cnt++;
      total++; if (t_mr[1] !== 1 || t_maddr[1] !== a || t_mw[1] !== we) $display("FAIL rand%0d_mem got %0b %o we%0b exp 1 %o we%0b", k, t_mr[1], t_maddr[1], t_mw[1], a, we); else pass_cnt++;
      if (we) begin
        total++; if (t_mwdata[1] !== d) $display("FAIL rand%0d_wdata got %o exp %o", k, t_mwdata[1], d); else pass_cnt++;
        total++; if (t_busy[2] !== 0) $display("FAIL rand%0d_wbusy got %0b exp 0", k, t_busy[2]); else pass_cnt++;
        ref_mem[a] = d;
      end
      for (int i = 2; i <= 6; i++) begin
        total++;
        if (t_mr[i] || t_ig[i] || t_eg[i]) $display("FAIL rand%0d_extra c%0d got req%0b", k, i, t_mr[i]);
        else if (t_ir[i] !== (!we && !use_exec && i == 2 + L) || t_er[i] !== (!we && use_exec && i == 2 + L)) $display("FAIL rand%0d_rvalid c%0d got i%0b e%0b", k, i, t_ir[i], t_er[i]);
        else pass_cnt++;
      end
      if (!we) begin
        total++; if ((use_exec ? t_erd[2+L] : t_ird[2+L]) !== ref_mem[a]) $display("FAIL rand%0d_rdata got %o exp %o", k, use_exec ? t_erd[2+L] : t_ird[2+L], ref_mem[a]); else pass_cnt++;
        total++; if (t_busy[3+L] !== 0) $display("FAIL rand%0d_rbusy got %0b exp 0", k, t_busy[3+L]); else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_read();
    preload(12'o0202, 12'o3210);
    ifd_addr = 12'o0202; ifd_req = 1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        total++; if (ifd_gnt !== 1) $display("FAIL rst_mid_gnt got %0b exp 1", ifd_gnt); else pass_cnt++;
        ifd_req = 0;
      end
      if (i == 2) reset_n = 0;
      if (i == 3) begin
        total++; if (busy !== 0 || ifd_gnt !== 0 || exec_gnt !== 0) $display("FAIL rst_mid_state got busy%0b", busy); else pass_cnt++;
        total++; if ({mem_req, mem_we, mem_addr, mem_wdata, ifd_rdata} !== 38'b0) $display("FAIL rst_mid_outs got %0b %o %o", mem_req, mem_addr, ifd_rdata); else pass_cnt++;
        reset_n = 1;
      end
      if (i >= 3) begin
        total++; if (ifd_rvalid !== 0 || exec_rvalid !== 0) $display("FAIL rst_mid_rvalid c%0d got %0b exp 0", i, ifd_rvalid); else pass_cnt++;
      end
    end
    ifd_addr = 12'o0202; ifd_req = 1;
    capture(6, 1, 0);
    total++; if (t_ig[1] !== 1 || t_maddr[1] !== 12'o0202) $display("FAIL rst_after_gnt got %0b %o", t_ig[1], t_maddr[1]); else pass_cnt++;
    total++; if (t_ir[2+L] !== 1 || t_ird[2+L] !== 12'o3210) $display("FAIL rst_after_data got %0b %o exp 1 3210", t_ir[2+L], t_ird[2+L]); else pass_cnt++;
    total++; if (t_busy[3+L] !== 0) $display("FAIL rst_after_busy got %0b exp 0", t_busy[3+L]); else pass_cnt++;
  endtask

  task automatic test_lat1();
    preload(12'o0177, 12'o5555);
    ifd_addr1 = 12'o0177; ifd_req1 = 1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      total++; if (mem_req1 !== (i == 1) || ifd_gnt1 !== (i == 1)) $display("FAIL lat1_req c%0d got %0b/%0b exp %0b", i, mem_req1, ifd_gnt1, i == 1); else pass_cnt++;
      total++; if (ifd_rvalid1 !== (i == 3) || exec_rvalid1 || exec_gnt1 || mem_we1) $display("FAIL lat1_rvalid c%0d got %0b exp %0b", i, ifd_rvalid1, i == 3); else pass_cnt++;
      total++; if (busy1 !== (i <= 3)) $display("FAIL lat1_busy c%0d got %0b exp %0b", i, busy1, i <= 3); else pass_cnt++;
      if (i == 1) begin
        total++; if (mem_addr1 !== 12'o0177) $display("FAIL lat1_addr got %o exp 0177", mem_addr1); else pass_cnt++;
        ifd_req1 = 0;
      end
      if (i == 2) ifd_addr1 = 12'o0200;
      if (i == 3) begin
        total++; if (ifd_rdata1 !== 12'o5555) $display("FAIL lat1_data got %o exp 5555", ifd_rdata1); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ifd_read();
    test_simultaneous();
    test_exec_write();
    test_fairness();
    test_random();
    test_reset_mid_read();
    test_lat1();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/pdp8_mem_arbiter.md
Name: pdp8_mem_arbiter

Overview:
- Shares the single-port PDP-8 main memory between two requesters: the instruction fetch/decode unit (IFD, read-only fetches) and the EXEC unit (operand reads and writes).
- Sits between IFD/EXEC and the memory model.
- Grants one transaction at a time with registered handshakes and a fixed-latency read return.
- EXEC has priority; a fairness counter bounds IFD starvation.

Parameters:
- ADDR_WIDTH, 12, memory address width (PDP-8 word address).
- DATA_WIDTH, 12, memory word width.
- MEM_LATENCY, 2, cycles from the mem_req cycle to valid mem_rdata; legal range 1..7.
- MAX_EXEC_BURST, 4, maximum consecutive EXEC grants while ifd_req is pending; legal range 1..15.

Ports:
- clk  input  1  free-running clock
- reset_n  input  1  reset, synchronous, active-low; clock clk
- ifd_req  input  1  IFD fetch request; held until ifd_gnt
- ifd_addr  input  ADDR_WIDTH  IFD fetch address; stable while ifd_req is high
- ifd_gnt  output  1  one-cycle pulse: IFD request accepted
- ifd_rdata  output  DATA_WIDTH  fetched word; valid with ifd_rvalid
- ifd_rvalid  output  1  one-cycle pulse: ifd_rdata valid
- exec_req  input  1  EXEC request; held until exec_gnt
- exec_we  input  1  1 = write, 0 = read
- exec_addr  input  ADDR_WIDTH  EXEC address
- exec_wdata  input  DATA_WIDTH  EXEC write data
- exec_gnt  output  1  one-cycle pulse: EXEC request accepted (for writes, this also signals completion)
- exec_rdata  output  DATA_WIDTH  read word; valid with exec_rvalid
- exec_rvalid  output  1  one-cycle pulse: exec_rdata valid (reads only)
- mem_req  output  1  one-cycle memory access strobe
- mem_we  output  1  memory write enable; qualified by mem_req
- mem_addr  output  ADDR_WIDTH  memory address; qualified by mem_req
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data; valid MEM_LATENCY cycles after the mem_req cycle
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE, streak counter 0, latency counter 0.
  - Reset applies in any state; an in-flight read is discarded and produces no rvalid.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples ifd_req and exec_req at each clock edge.
  - If either is high, latches owner, addr, we (IFD forces 0) and wdata, then moves to ISSUE.
  - If neither is high, stays in IDLE.
- Arbitration (evaluated in IDLE):
  - Only one requester: that requester wins.
  - Both requesting: EXEC wins unless streak == MAX_EXEC_BURST, in which case IFD wins.
  - An EXEC win with ifd_req high increments streak.
  - An IFD win, or any arbitration with ifd_req low, clears streak.
- ISSUE (exactly 1 cycle):
  - Owner's gnt = 1.
  - mem_req = 1; mem_we/mem_addr/mem_wdata driven from latched values.
  - Write: next state IDLE.
  - Read: next state WAIT, latency counter loaded with MEM_LATENCY-1.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0 (this is the cycle mem_req + MEM_LATENCY), capture mem_rdata and go to RESP.
  - With MEM_LATENCY = 1, WAIT lasts one cycle.
- RESP (1 cycle):
  - Owner's rvalid = 1.
  - Owner's rdata holds the captured word and keeps it until the next capture.
  - Next state IDLE.
- Latency with the arbiter idle, request sampled at edge N:
  - gnt and mem_req in cycle N+1.
  - rvalid in cycle N+2+MEM_LATENCY.
  - IDLE again at N+3+MEM_LATENCY.
  - Write: back in IDLE at N+2.
- Handshake rules:
  - A requester may drop req or change addr/wdata in the cycle after its gnt.
  - Inputs after the latch point are ignored.
  - A req still high during ISSUE/WAIT/RESP is not re-sampled until IDLE.
- mem_addr, mem_we and mem_wdata return to 0 when mem_req is 0.
- At most one gnt and at most one rvalid per cycle. There are never overlapping memory transactions.

Decomposition:
- pdp8_pkg additions:
  - typedef enum arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}.
  - typedef enum mem_owner_e {OWN_IFD, OWN_EXEC}.
  - Existing `ADDR_WIDTH / DATA_WIDTH constants are reused for parameter defaults.
- One sub-module, pdp8_mem_arb_sel:
  - Holds the priority pick plus the streak counter.
  - Inputs: clk, reset_n, ifd_req, exec_req, arb_en.
  - Outputs: pick_valid, pick_owner.
- The top level owns the FSM, the latches and the latency counter.

Test Plan:
- IFD-only read, MEM_LATENCY = 2: ifd_req with ifd_addr = 12'o0200 sampled at N; memory returns 12'o7402 → ifd_gnt, mem_req and mem_addr = 0200 in N+1; ifd_rvalid with ifd_rdata = 7402 in N+4; busy high N+1..N+4, low N+5.
- Simultaneous requests at N (EXEC read 12'o0300, IFD read 12'o0201) → exec_gnt N+1, exec_rvalid N+4; ifd_gnt N+6 with mem_addr = 0201; ifd_rvalid N+9.
- EXEC write exec_addr = 12'o0310, exec_wdata = 12'o1234 → mem_req = mem_we = 1, mem_wdata = 1234, exec_gnt all in N+1 only; no exec_rvalid; busy low at N+2; an IFD request at N+2 gets gnt at N+3.
- Fairness, MAX_EXEC_BURST = 4: both req held continuously (EXEC reads) → grant sequence E,E,E,E,I,E,E,E,E,I; no IFD wait exceeds 4 EXEC transactions.
- Reset mid-read: reset_n low for 1 cycle during WAIT → next cycle busy = 0 and all gnt/rvalid/mem_* = 0; no rvalid ever for the aborted read; a fresh IFD read afterwards completes with normal timing.
- MEM_LATENCY = 1 build: IFD read 12'o0177 sampled at N → mem_req N+1, ifd_rvalid N+3; changing ifd_addr at N+2 does not alter the returned word.
